// File: rtl/fifo_prog_full_pkg.sv
// Helpers shared by the FIFO top: modulo-DEPTH pointer increment and the
// prog-full threshold rule.
package fifo_prog_full_pkg;

   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr + 1 >= depth) ? 0 : ptr + 1;
   endfunction

   function automatic logic prog_full_at(input int unsigned count, input int unsigned depth,
                                         input int unsigned grace);
      return (count + grace >= depth);
   endfunction

endpackage

// File: rtl/fifo_prog_full_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_prog_full_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_prog_full.sv
// First-word fall-through FIFO with registered head, occupancy count and a
// programmable almost-full flag. Capacity DEPTH counts the head register.
module fifo_prog_full
   import fifo_prog_full_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int DEPTH        = 32,
   parameter int GRACE_PERIOD = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  if_full_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_empty_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_prog_full,
   output logic [ADDR_WIDTH:0]   if_count
);

   localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] C_ONE   = (ADDR_WIDTH+1)'(1);

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_full_n;
   logic                  r_empty_n;
   logic                  r_prog_full;
   logic [DATA_WIDTH-1:0] r_dout;

   logic                  w_wr;
   logic                  w_rd;
   logic                  w_load;
   logic [ADDR_WIDTH:0]   w_mem_cnt;
   logic [ADDR_WIDTH:0]   w_count_nxt;
   logic [DATA_WIDTH-1:0] w_mem_rdata;

   assign w_wr = if_write & if_write_ce & r_full_n;
   assign w_rd = if_read & if_read_ce & r_empty_n;

   // Words still in the array, i.e. total occupancy minus the head register.
   assign w_mem_cnt = r_count - {{ADDR_WIDTH{1'b0}}, r_empty_n};
   assign w_load    = (w_mem_cnt != '0) & (~r_empty_n | w_rd);

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr & ~w_rd)      w_count_nxt = r_count + C_ONE;
      else if (w_rd & ~w_wr) w_count_nxt = r_count - C_ONE;
   end

   fifo_prog_full_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_wr),
      .i_waddr (r_wr_ptr),
      .i_wdata (if_din),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_full_n    <= 1'b1;
         r_empty_n   <= 1'b0;
         r_prog_full <= prog_full_at(0, DEPTH, GRACE_PERIOD);
         r_dout      <= '0;
      end else begin
         r_count     <= w_count_nxt;
         r_full_n    <= (w_count_nxt != C_DEPTH);
         r_prog_full <= prog_full_at(32'(w_count_nxt), DEPTH, GRACE_PERIOD);
         if (w_wr) r_wr_ptr <= ADDR_WIDTH'(ptr_inc(32'(r_wr_ptr), DEPTH));
         // The head refills from the array whenever it is empty or being popped.
         if (w_load) begin
            r_dout    <= w_mem_rdata;
            r_rd_ptr  <= ADDR_WIDTH'(ptr_inc(32'(r_rd_ptr), DEPTH));
            r_empty_n <= 1'b1;
         end else if (w_rd) begin
            r_empty_n <= 1'b0;
         end
      end
   end

   assign if_full_n    = r_full_n;
   assign if_empty_n   = r_empty_n;
   assign if_prog_full = r_prog_full;
   assign if_count     = r_count;
   assign if_dout      = r_dout;

endmodule

// File: tb/tb_fifo_prog_full.sv
// Bench for fifo_prog_full: a 32-deep instance for directed scenarios and a
// 5-deep instance for long randomized traffic across pointer wrap.
module tb_fifo_prog_full;

   localparam int A_AW = 5, A_DEPTH = 32, A_GRACE = 2;
   localparam int B_AW = 3, B_DEPTH = 5,  B_GRACE = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic a_rst = 1'b1, a_wce = 1'b0, a_w = 1'b0, a_rce = 1'b0, a_r = 1'b0;
   logic [31:0] a_din = '0;
   logic a_full_n, a_empty_n, a_pf;
   logic [31:0] a_dout;
   logic [A_AW:0] a_count;

   logic b_rst = 1'b1, b_wce = 1'b0, b_w = 1'b0, b_rce = 1'b0, b_r = 1'b0;
   logic [31:0] b_din = '0;
   logic b_full_n, b_empty_n, b_pf;
   logic [31:0] b_dout;
   logic [B_AW:0] b_count;

   fifo_prog_full #(.DATA_WIDTH(32), .ADDR_WIDTH(A_AW), .DEPTH(A_DEPTH), .GRACE_PERIOD(A_GRACE)) u_a (
      .clk(clk), .reset(a_rst), .if_full_n(a_full_n), .if_write_ce(a_wce), .if_write(a_w),
      .if_din(a_din), .if_empty_n(a_empty_n), .if_read_ce(a_rce), .if_read(a_r),
      .if_dout(a_dout), .if_prog_full(a_pf), .if_count(a_count));

   fifo_prog_full #(.DATA_WIDTH(32), .ADDR_WIDTH(B_AW), .DEPTH(B_DEPTH), .GRACE_PERIOD(B_GRACE)) u_b (
      .clk(clk), .reset(b_rst), .if_full_n(b_full_n), .if_write_ce(b_wce), .if_write(b_w),
      .if_din(b_din), .if_empty_n(b_empty_n), .if_read_ce(b_rce), .if_read(b_r),
      .if_dout(b_dout), .if_prog_full(b_pf), .if_count(b_count));

   // Reference model: queue of words plus the cycle each was written. The head
   // becomes visible once at least one edge has passed since its write.
   logic [31:0] a_exp_q[$];
   int          a_t_q[$];
   int          ea_count;
   logic        ea_full_n, ea_empty_n, ea_pf;
   logic [31:0] ea_dout;

   logic [31:0] b_exp_q[$];
   int          b_t_q[$];
   int          eb_count;
   logic        eb_full_n, eb_empty_n, eb_pf;
   logic [31:0] eb_dout;

   task automatic step_a(input logic rst, input logic wce, input logic w, input logic [31:0] din,
                         input logic rce, input logic r);
      logic acc_w, acc_r;
      logic [31:0] tmp;
      int tt;
      a_rst = rst; a_wce = wce; a_w = w; a_din = din; a_rce = rce; a_r = r;
      acc_w = w && wce && (a_exp_q.size() < A_DEPTH);
      acc_r = r && rce && ea_empty_n;
      @(posedge clk);
      cyc++;
      if (rst) begin
         a_exp_q.delete(); a_t_q.delete(); ea_dout = '0;
      end else begin
         if (acc_r) begin tmp = a_exp_q.pop_front(); tt = a_t_q.pop_front(); end
         if (acc_w) begin a_exp_q.push_back(din); a_t_q.push_back(cyc); end
      end
      ea_count   = a_exp_q.size();
      ea_empty_n = (ea_count > 0) && (a_t_q[0] < cyc);
      if (ea_empty_n) ea_dout = a_exp_q[0];
      ea_full_n  = (ea_count != A_DEPTH);
      ea_pf      = (ea_count >= A_DEPTH - A_GRACE);
      #1;
      a_rst = 1'b0; a_wce = 1'b0; a_w = 1'b0; a_rce = 1'b0; a_r = 1'b0;
   endtask

   task automatic step_b(input logic rst, input logic wce, input logic w, input logic [31:0] din,
                         input logic rce, input logic r);
      logic acc_w, acc_r;
      logic [31:0] tmp;
      int tt;
      b_rst = rst; b_wce = wce; b_w = w; b_din = din; b_rce = rce; b_r = r;
      acc_w = w && wce && (b_exp_q.size() < B_DEPTH);
      acc_r = r && rce && eb_empty_n;
      @(posedge clk);
      cyc++;
      if (rst) begin
         b_exp_q.delete(); b_t_q.delete(); eb_dout = '0;
      end else begin
         if (acc_r) begin tmp = b_exp_q.pop_front(); tt = b_t_q.pop_front(); end
         if (acc_w) begin b_exp_q.push_back(din); b_t_q.push_back(cyc); end
      end
      eb_count   = b_exp_q.size();
      eb_empty_n = (eb_count > 0) && (b_t_q[0] < cyc);
      if (eb_empty_n) eb_dout = b_exp_q[0];
      eb_full_n  = (eb_count != B_DEPTH);
      eb_pf      = (eb_count >= B_DEPTH - B_GRACE);
      #1;
      b_rst = 1'b0; b_wce = 1'b0; b_w = 1'b0; b_rce = 1'b0; b_r = 1'b0;
   endtask

   task automatic drain_a();
      for (int i = 0; i < A_DEPTH + 2; i++) step_a(0, 0, 0, '0, 1, 1);
   endtask

   task automatic test_reset();
      step_a(1, 1, 1, 32'hdead, 1, 1);
      step_b(1, 1, 1, 32'hbeef, 1, 1);
      total++;
      if ({a_count, a_full_n, a_empty_n, a_pf} !== {6'd0, 1'b1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL reset_a_status: got %h want %h", {a_count, a_full_n, a_empty_n, a_pf}, {6'd0, 3'b100});
      end
      total++;
      if (a_dout !== 32'h0) begin bad++; $display("FAIL reset_a_dout: got %h want 0", a_dout); end
      total++;
      if ({b_count, b_full_n, b_empty_n, b_pf} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL reset_b_status: got %h want %h", {b_count, b_full_n, b_empty_n, b_pf}, {4'd0, 3'b100});
      end
      total++;
      if (b_dout !== 32'h0) begin bad++; $display("FAIL reset_b_dout: got %h want 0", b_dout); end
      step_a(0, 1, 1, 32'h11, 0, 0);
      total++;
      if (a_count !== 6'd1) begin bad++; $display("FAIL first_write_after_reset: got %0d want 1", a_count); end
      drain_a();
   endtask

   task automatic test_latency();
      step_a(0, 1, 1, 32'hA5, 0, 0);
      total++;
      if ({a_empty_n, a_count} !== {1'b0, 6'd1}) begin
         bad++; $display("FAIL latency_early: got empty_n=%b count=%0d want empty_n=0 count=1", a_empty_n, a_count);
      end
      step_a(0, 0, 0, '0, 0, 0);
      total++;
      if ({a_empty_n, a_dout} !== {1'b1, 32'hA5}) begin
         bad++; $display("FAIL latency_visible: got empty_n=%b dout=%h want 1 a5", a_empty_n, a_dout);
      end
      drain_a();
   endtask

   task automatic test_fill();
      for (int i = 0; i < A_DEPTH; i++) begin
         step_a(0, 1, 1, 32'(i), 0, 0);
         total++;
         if ({a_count, a_full_n, a_empty_n, a_pf} !== {6'(ea_count), ea_full_n, ea_empty_n, ea_pf}) begin
            bad++; $display("FAIL fill_status[%0d]: got %h want %h", i, {a_count, a_full_n, a_empty_n, a_pf},
                            {6'(ea_count), ea_full_n, ea_empty_n, ea_pf});
         end
      end
      step_a(0, 1, 1, 32'd99, 0, 0);
      total++;
      if ({a_count, a_full_n, a_pf} !== {6'd32, 1'b0, 1'b1}) begin
         bad++; $display("FAIL fill_overflow: got count=%0d full_n=%b pf=%b want 32 0 1", a_count, a_full_n, a_pf);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < A_DEPTH; i++) begin
         total++;
         if ({a_empty_n, a_dout} !== {1'b1, 32'(i)}) begin
            bad++; $display("FAIL drain_data[%0d]: got empty_n=%b dout=%h want 1 %h", i, a_empty_n, a_dout, i);
         end
         step_a(0, 0, 0, '0, 1, 1);
         total++;
         if ({a_count, a_full_n, a_empty_n, a_pf} !== {6'(ea_count), ea_full_n, ea_empty_n, ea_pf}) begin
            bad++; $display("FAIL drain_status[%0d]: got %h want %h", i, {a_count, a_full_n, a_empty_n, a_pf},
                            {6'(ea_count), ea_full_n, ea_empty_n, ea_pf});
         end
      end
   endtask

   task automatic test_simultaneous();
      step_a(0, 1, 1, 32'h77, 1, 1);
      total++;
      if (a_count !== 6'd1) begin bad++; $display("FAIL empty_rw_count: got %0d want 1", a_count); end
      drain_a();
      for (int i = 0; i < 5; i++) step_a(0, 1, 1, $urandom, 0, 0);
      step_a(0, 0, 0, '0, 0, 0);
      for (int i = 0; i < 100; i++) begin
         step_a(0, 1, 1, $urandom, 1, 1);
         total++;
         if ({a_count, a_empty_n, a_dout} !== {6'd5, 1'b1, ea_dout}) begin
            bad++; $display("FAIL steady_rw[%0d]: got count=%0d empty_n=%b dout=%h want 5 1 %h",
                            i, a_count, a_empty_n, a_dout, ea_dout);
         end
      end
      for (int i = 0; i < 30; i++) step_a(0, 1, 1, $urandom, 0, 0);
      step_a(0, 0, 0, '0, 0, 0);
      total++;
      if ({a_count, a_full_n, a_dout} !== {6'd32, 1'b0, ea_dout}) begin
         bad++; $display("FAIL refill: got count=%0d full_n=%b dout=%h want 32 0 %h", a_count, a_full_n, a_dout, ea_dout);
      end
      step_a(0, 1, 1, 32'h55, 1, 1);
      total++;
      if ({a_count, a_full_n, a_dout} !== {6'd31, 1'b1, ea_dout}) begin
         bad++; $display("FAIL full_rw: got count=%0d full_n=%b dout=%h want 31 1 %h", a_count, a_full_n, a_dout, ea_dout);
      end
      while (a_exp_q.size() > 0 && cyc < 20000) begin
         total++;
         if ({a_empty_n, a_dout} !== {ea_empty_n, ea_dout} && ea_empty_n) begin
            bad++; $display("FAIL tail_drain: got %b %h want %b %h", a_empty_n, a_dout, ea_empty_n, ea_dout);
         end
         step_a(0, 0, 0, '0, 1, 1);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 17; i++) step_a(0, 1, 1, 32'h100 + 32'(i), 0, 0);
      total++;
      if (a_count !== 6'd17) begin bad++; $display("FAIL pre_reset_count: got %0d want 17", a_count); end
      step_a(1, 1, 1, 32'hfeed, 1, 1);
      total++;
      if ({a_count, a_full_n, a_empty_n, a_pf, a_dout} !== {6'd0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
         bad++; $display("FAIL reset_mid: got count=%0d full_n=%b empty_n=%b pf=%b dout=%h want 0 1 0 0 0",
                         a_count, a_full_n, a_empty_n, a_pf, a_dout);
      end
      step_a(0, 0, 0, '0, 0, 0);
      total++;
      if ({a_count, a_empty_n} !== {6'd0, 1'b0}) begin
         bad++; $display("FAIL reset_mid_settle: got count=%0d empty_n=%b want 0 0", a_count, a_empty_n);
      end
   endtask

   task automatic test_random_wrap();
      int wp, rp;
      wp = 50; rp = 50;
      step_b(1, 0, 0, '0, 0, 0);
      for (int c = 0; c < 10000; c++) begin
         if (c % 400 == 0) begin wp = $urandom_range(10, 90); rp = $urandom_range(10, 90); end
         step_b(0, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < wp, $urandom,
                $urandom_range(0, 99) < 85, $urandom_range(0, 99) < rp);
         total++;
         if ({b_count, b_full_n, b_empty_n, b_pf} !== {4'(eb_count), eb_full_n, eb_empty_n, eb_pf}) begin
            bad++; $display("FAIL rand_status[%0d]: got %h want %h", c, {b_count, b_full_n, b_empty_n, b_pf},
                            {4'(eb_count), eb_full_n, eb_empty_n, eb_pf});
         end
         if (eb_empty_n) begin
            total++;
            if (b_dout !== eb_dout) begin
               bad++; $display("FAIL rand_data[%0d]: got %h want %h", c, b_dout, eb_dout);
            end
         end
      end
      for (int i = 0; i < B_DEPTH + 2; i++) step_b(0, 0, 0, '0, 1, 1);
      total++;
      if ({b_count, b_empty_n} !== {4'd0, 1'b0}) begin
         bad++; $display("FAIL rand_final: got count=%0d empty_n=%b want 0 0", b_count, b_empty_n);
      end
   endtask

   initial begin
      ea_count = 0; ea_full_n = 1'b1; ea_empty_n = 1'b0; ea_pf = 1'b0; ea_dout = '0;
      eb_count = 0; eb_full_n = 1'b1; eb_empty_n = 1'b0; eb_pf = 1'b0; eb_dout = '0;
      @(negedge clk);
      test_reset();
      test_latency();
      test_fill();
      test_drain();
      test_simultaneous();
      test_reset_mid();
      test_random_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
